// File: rtl/dma_pingpong_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_buffer_pkg
// Brief   : Shared types and width helpers for the ping-pong DMA buffer.
// Rev     : 1.0
// ============================================================================
package dma_buffer_pkg;

    localparam int NR_OF_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2
    } bank_state_t;

    function automatic int addr_width(input int entries);
        return $clog2(entries);
    endfunction

    // One extra bit so a completely full bank can report NR_OF_ENTRIES words.
    function automatic int count_width(input int entries);
        return $clog2(entries) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : dma_pingpong_buffer_if
// Brief     : Fill/drain bus of the ping-pong buffer; the byte-enable lane
//             field exists only when DMA_BUF_BYTE_ENABLE_EN is defined.
// Rev       : 1.0
// ============================================================================
interface dma_pingpong_buffer_if #(
    parameter int BITWIDTH      = 32,
    parameter int NR_OF_ENTRIES = 512
);
    localparam int AW = dma_buffer_pkg::addr_width(NR_OF_ENTRIES);
    localparam int CW = dma_buffer_pkg::count_width(NR_OF_ENTRIES);

    logic                fillValid;
    logic [BITWIDTH-1:0] fillData;
    logic                fillLast;
    logic                fillReady;
    logic [CW-1:0]       fillCount;
    logic [AW-1:0]       drainAddress;
    logic [BITWIDTH-1:0] drainData;
    logic                drainAvailable;
    logic [CW-1:0]       drainWordCount;
    logic                drainRelease;
    logic                overflowError;
`ifdef DMA_BUF_BYTE_ENABLE_EN
    logic [BITWIDTH/8-1:0] fillByteEnable;

    modport master (
        output fillValid, fillData, fillLast, fillByteEnable, drainAddress, drainRelease,
        input  fillReady, fillCount, drainData, drainAvailable, drainWordCount, overflowError
    );
    modport slave (
        input  fillValid, fillData, fillLast, fillByteEnable, drainAddress, drainRelease,
        output fillReady, fillCount, drainData, drainAvailable, drainWordCount, overflowError
    );
`else
    modport master (
        output fillValid, fillData, fillLast, drainAddress, drainRelease,
        input  fillReady, fillCount, drainData, drainAvailable, drainWordCount, overflowError
    );
    modport slave (
        input  fillValid, fillData, fillLast, drainAddress, drainRelease,
        output fillReady, fillCount, drainData, drainAvailable, drainWordCount, overflowError
    );
`endif

endinterface
`default_nettype wire

// File: rtl/dma_pingpong_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module : dma_buffer_ram
// Brief  : Single-clock simple dual-port RAM with lane write mask and
//          registered read output.
// Rev    : 1.0
// ============================================================================
module dma_buffer_ram #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 1024,
    parameter int LANES    = 1
) (
    input  wire logic                      clock,
    input  wire logic                      resetN,
    input  wire logic                      i_wr_en,
    input  wire logic [$clog2(DEPTH)-1:0]  i_wr_addr,
    input  wire logic [BITWIDTH-1:0]       i_wr_data,
    input  wire logic [LANES-1:0]          i_wr_mask,
    input  wire logic [$clog2(DEPTH)-1:0]  i_rd_addr,
    output logic      [BITWIDTH-1:0]       o_rd_data
);
    localparam int LANE_W = BITWIDTH / LANES;

    logic [BITWIDTH-1:0] r_mem [DEPTH];

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wr_mask[l]) begin
                    r_mem[i_wr_addr][l*LANE_W +: LANE_W] <= i_wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module : dma_pingpong_buffer
// Brief  : Two-bank ping-pong staging buffer with bank ownership handshake,
//          word counts and sticky overflow. Option: DMA_BUF_BYTE_ENABLE_EN.
// Rev    : 1.0
// ============================================================================
module dma_pingpong_buffer
    import dma_buffer_pkg::*;
#(
    parameter int BITWIDTH      = 32,
    parameter int NR_OF_ENTRIES = 512
) (
    input wire logic               clock,
    input wire logic               resetN,
    dma_pingpong_buffer_if.slave   bus
);
    localparam int AW = addr_width(NR_OF_ENTRIES);
    localparam int CW = count_width(NR_OF_ENTRIES);
`ifdef DMA_BUF_BYTE_ENABLE_EN
    localparam int LANES = BITWIDTH / 8;
`else
    localparam int LANES = 1;
`endif

    bank_state_t   r_bank_state     [NR_OF_BANKS];
    bank_state_t   w_bank_state_nxt [NR_OF_BANKS];
    logic [CW-1:0] r_bank_count     [NR_OF_BANKS];
    logic          r_fill_bank;
    logic          r_drain_bank;
    logic [CW-1:0] r_fill_count;
    logic          r_overflow;

    logic          w_fill_ready;
    logic          w_drain_avail;
    logic          w_accept;
    logic          w_commit;
    logic          w_release;
    logic [LANES-1:0]    w_wr_mask;
    logic [BITWIDTH-1:0] w_drain_data;

`ifdef DMA_BUF_BYTE_ENABLE_EN
    assign w_wr_mask = bus.fillByteEnable;
`else
    assign w_wr_mask = '1;
`endif

    // Fill and drain never own the same bank at once: accept needs a non-READY
    // fill bank, release needs a READY drain bank.
    always_comb begin
        w_fill_ready     = (r_bank_state[r_fill_bank] != BANK_READY);
        w_drain_avail    = (r_bank_state[r_drain_bank] == BANK_READY);
        w_accept         = bus.fillValid && w_fill_ready;
        w_commit         = w_accept &&
                           (bus.fillLast || (r_fill_count == CW'(NR_OF_ENTRIES - 1)));
        w_release        = bus.drainRelease && w_drain_avail;
        w_bank_state_nxt = r_bank_state;
        if (w_accept) begin
            w_bank_state_nxt[r_fill_bank] = w_commit ? BANK_READY : BANK_FILLING;
        end
        if (w_release) begin
            w_bank_state_nxt[r_drain_bank] = BANK_FREE;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_bank_state <= '{BANK_FREE, BANK_FREE};
            r_bank_count <= '{'0, '0};
            r_fill_bank  <= 1'b0;
            r_drain_bank <= 1'b0;
            r_fill_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_bank_state <= w_bank_state_nxt;
            if (w_commit) begin
                r_bank_count[r_fill_bank] <= r_fill_count + CW'(1);
                r_fill_bank               <= ~r_fill_bank;
                r_fill_count              <= '0;
            end else if (w_accept) begin
                r_fill_count <= r_fill_count + CW'(1);
            end
            if (w_release) begin
                r_drain_bank <= ~r_drain_bank;
            end
            if (bus.fillValid && !w_fill_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    dma_buffer_ram #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (NR_OF_BANKS * NR_OF_ENTRIES),
        .LANES    (LANES)
    ) u_ram (
        .clock     (clock),
        .resetN    (resetN),
        .i_wr_en   (w_accept),
        .i_wr_addr ({r_fill_bank, r_fill_count[AW-1:0]}),
        .i_wr_data (bus.fillData),
        .i_wr_mask (w_wr_mask),
        .i_rd_addr ({r_drain_bank, bus.drainAddress}),
        .o_rd_data (w_drain_data)
    );

    assign bus.fillReady      = w_fill_ready;
    assign bus.fillCount      = r_fill_count;
    assign bus.drainData      = w_drain_data;
    assign bus.drainAvailable = w_drain_avail;
    assign bus.drainWordCount = w_drain_avail ? r_bank_count[r_drain_bank] : '0;
    assign bus.overflowError  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dma_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_pingpong_buffer
// Brief  : Directed scoreboard bench for dma_pingpong_buffer (4-entry banks).
// Rev    : 1.0
// ============================================================================
module tb_dma_pingpong_buffer;

    localparam int BW = 32;
    localparam int NE = 4;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    dma_pingpong_buffer_if #(.BITWIDTH(BW), .NR_OF_ENTRIES(NE)) bus ();

    dma_pingpong_buffer #(.BITWIDTH(BW), .NR_OF_ENTRIES(NE)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] exp_q [$];
    logic          rd_req  = 1'b0;
    logic          rd_pend = 1'b0;

    always @(posedge clock) rd_pend <= rd_req;

    // Read-data monitor: one cycle after a read is issued, pop and compare.
    always @(negedge clock) begin
        if (rd_pend) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: got %h with no expected entry queued", bus.drainData);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                if (bus.drainData !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", bus.drainData, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [BW-1:0] d, input logic last);
        bus.fillValid = 1'b1;
        bus.fillData  = d;
        bus.fillLast  = last;
        tick();
        bus.fillValid = 1'b0;
        bus.fillLast  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [BW-1:0] e);
        bus.drainAddress = a;
        exp_q.push_back(e);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic release_bank();
        bus.drainRelease = 1'b1;
        tick();
        bus.drainRelease = 1'b0;
    endtask

    initial begin
        bus.fillValid    = 1'b0;
        bus.fillData     = '0;
        bus.fillLast     = 1'b0;
        bus.drainAddress = '0;
        bus.drainRelease = 1'b0;
`ifdef DMA_BUF_BYTE_ENABLE_EN
        bus.fillByteEnable = '1;
`endif
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // Reset state
        chk("rst_fillReady", 32'(bus.fillReady), 32'd1);
        chk("rst_drainAvail", 32'(bus.drainAvailable), 32'd0);
        chk("rst_fillCount", 32'(bus.fillCount), 32'd0);
        chk("rst_overflow", 32'(bus.overflowError), 32'd0);
        chk("rst_drainCount", 32'(bus.drainWordCount), 32'd0);
        chk("rst_drainData", bus.drainData, 32'd0);

        // Short block into bank 0
        fill(32'h11, 1'b0);
        chk("short_fillCount1", 32'(bus.fillCount), 32'd1);
        chk("short_avail_mid", 32'(bus.drainAvailable), 32'd0);
        fill(32'h22, 1'b0);
        fill(32'h33, 1'b1);
        chk("short_avail", 32'(bus.drainAvailable), 32'd1);
        chk("short_count", 32'(bus.drainWordCount), 32'd3);
        chk("short_fillCount0", 32'(bus.fillCount), 32'd0);
        chk("short_fillReady", 32'(bus.fillReady), 32'd1);
        rd(2'd2, 32'h33);
        rd(2'd0, 32'h11);
        rd(2'd1, 32'h22);

        // fillLast without fillValid does nothing
        bus.fillLast = 1'b1;
        tick();
        bus.fillLast = 1'b0;
        chk("lastonly_fillCount", 32'(bus.fillCount), 32'd0);
        chk("lastonly_count", 32'(bus.drainWordCount), 32'd3);

        release_bank();
        chk("rel_avail", 32'(bus.drainAvailable), 32'd0);
        chk("rel_count", 32'(bus.drainWordCount), 32'd0);

        // Reset mid-fill of bank 1
        fill(32'h44, 1'b0);
        fill(32'h55, 1'b0);
        chk("midrst_fillCount_pre", 32'(bus.fillCount), 32'd2);
        resetN = 1'b0;
        #1;
        chk("midrst_fillCount", 32'(bus.fillCount), 32'd0);
        chk("midrst_avail", 32'(bus.drainAvailable), 32'd0);
        chk("midrst_fillReady", 32'(bus.fillReady), 32'd1);
        tick();
        resetN = 1'b1;
        tick();

        // Auto-commit into bank 0 after four words
        fill(32'hA0, 1'b0);
        fill(32'hA1, 1'b0);
        fill(32'hA2, 1'b0);
        chk("auto_avail_pre", 32'(bus.drainAvailable), 32'd0);
        fill(32'hA3, 1'b0);
        chk("auto_avail", 32'(bus.drainAvailable), 32'd1);
        chk("auto_count", 32'(bus.drainWordCount), 32'd4);
        chk("auto_fillReady1", 32'(bus.fillReady), 32'd1);
        rd(2'd3, 32'hA3);
        fill(32'hB0, 1'b0);
        fill(32'hB1, 1'b0);
        fill(32'hB2, 1'b0);
        fill(32'hB3, 1'b0);
        chk("both_fillReady", 32'(bus.fillReady), 32'd0);

        // Overflow: word dropped, sticky flag
        chk("ovf_pre", 32'(bus.overflowError), 32'd0);
        fill(32'hDEAD, 1'b0);
        chk("ovf_set", 32'(bus.overflowError), 32'd1);
        tick();
        chk("ovf_sticky", 32'(bus.overflowError), 32'd1);
        chk("ovf_fillCount", 32'(bus.fillCount), 32'd0);
        chk("ovf_count", 32'(bus.drainWordCount), 32'd4);
        rd(2'd0, 32'hA0);

        // Release bank 0, drain bank 1
        release_bank();
        chk("rel0_avail", 32'(bus.drainAvailable), 32'd1);
        chk("rel0_count", 32'(bus.drainWordCount), 32'd4);
        chk("rel0_fillReady", 32'(bus.fillReady), 32'd1);
        rd(2'd1, 32'hB1);

        // Commit bank 0 on the same edge as release of bank 1
        fill(32'hC0, 1'b0);
        bus.drainRelease = 1'b1;
        fill(32'hC1, 1'b1);
        bus.drainRelease = 1'b0;
        chk("conc_avail", 32'(bus.drainAvailable), 32'd1);
        chk("conc_count", 32'(bus.drainWordCount), 32'd2);
        chk("conc_fillReady", 32'(bus.fillReady), 32'd1);
        chk("conc_fillCount", 32'(bus.fillCount), 32'd0);
        rd(2'd1, 32'hC1);
        rd(2'd0, 32'hC0);

        // Release with nothing available is ignored
        release_bank();
        chk("idle_avail", 32'(bus.drainAvailable), 32'd0);
        release_bank();
        fill(32'hD0, 1'b1);
        chk("ign_avail", 32'(bus.drainAvailable), 32'd1);
        chk("ign_count", 32'(bus.drainWordCount), 32'd1);
        rd(2'd0, 32'hD0);

`ifdef DMA_BUF_BYTE_ENABLE_EN
        // Byte-lane masked write over an all-ones word in bank 0
        release_bank();
        fill(32'hFFFF_FFFF, 1'b1);
        release_bank();
        fill(32'h0000_0000, 1'b1);
        release_bank();
        bus.fillByteEnable = 4'b0101;
        fill(32'h1234_5678, 1'b1);
        bus.fillByteEnable = '1;
        chk("be_count", 32'(bus.drainWordCount), 32'd1);
        rd(2'd0, 32'hFF34_FF78);
`endif

        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
